// File: rtl/axi_outstanding_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi_outstanding_buffer
// Brief    : Five-channel AXI FWFT buffer with per-direction outstanding limit.
// Revision : 1.0 - initial release
// ============================================================================

module axi_outstanding_buffer_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty
);
    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam int c_pw    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] r_mem [0:c_depth-1];
    logic [c_pw-1:0]  r_wptr;
    logic [c_pw-1:0]  r_rptr;
    logic [c_pw-1:0]  w_wptr_nxt;
    logic [c_pw-1:0]  w_rptr_nxt;
    logic             r_full;
    logic             r_init;
    logic             w_push;
    logic             w_pop;
    logic             w_full_nxt;

    // r_init keeps READY low until the first edge after reset release.
    assign o_push_ready = r_init && !r_full;
    assign o_empty      = (r_wptr == r_rptr);
    assign o_pop_valid  = !o_empty;
    assign o_pop_data   = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    always_comb begin
        w_wptr_nxt = r_wptr + c_pw'(w_push);
        w_rptr_nxt = r_rptr + c_pw'(w_pop);
        w_full_nxt = (w_wptr_nxt[DEPTH_LOG2] != w_rptr_nxt[DEPTH_LOG2]) &&
                     (w_wptr_nxt[DEPTH_LOG2-1:0] == w_rptr_nxt[DEPTH_LOG2-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
            r_init <= 1'b0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_full <= w_full_nxt;
            r_init <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_push_data;
        end
    end
endmodule

module axi_outstanding_buffer #(
    parameter int ID_WIDTH        = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_LOG2      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST,
    // S-side AW
    input  logic [ID_WIDTH-1:0]     S_WR_ADDR_ID,
    input  logic [31:0]             S_WR_ADDR,
    input  logic [7:0]              S_WR_ADDR_LEN,
    input  logic [1:0]              S_WR_ADDR_BURST,
    input  logic                    S_WR_ADDR_VALID,
    output logic                    S_WR_ADDR_READY,
    // S-side W
    input  logic [DATA_WIDTH-1:0]   S_WR_DATA,
    input  logic [DATA_WIDTH/8-1:0] S_WR_STRB,
    input  logic                    S_WR_DATA_LAST,
    input  logic                    S_WR_DATA_VALID,
    output logic                    S_WR_DATA_READY,
    // S-side B
    output logic [ID_WIDTH-1:0]     S_WR_BACK_ID,
    output logic [1:0]              S_WR_BACK_RESP,
    output logic                    S_WR_BACK_VALID,
    input  logic                    S_WR_BACK_READY,
    // S-side AR
    input  logic [ID_WIDTH-1:0]     S_RD_ADDR_ID,
    input  logic [31:0]             S_RD_ADDR,
    input  logic [7:0]              S_RD_ADDR_LEN,
    input  logic [1:0]              S_RD_ADDR_BURST,
    input  logic                    S_RD_ADDR_VALID,
    output logic                    S_RD_ADDR_READY,
    // S-side R
    output logic [ID_WIDTH-1:0]     S_RD_BACK_ID,
    output logic [DATA_WIDTH-1:0]   S_RD_DATA,
    output logic [1:0]              S_RD_DATA_RESP,
    output logic                    S_RD_DATA_LAST,
    output logic                    S_RD_DATA_VALID,
    input  logic                    S_RD_DATA_READY,
    // M-side AW
    output logic [ID_WIDTH-1:0]     M_WR_ADDR_ID,
    output logic [31:0]             M_WR_ADDR,
    output logic [7:0]              M_WR_ADDR_LEN,
    output logic [1:0]              M_WR_ADDR_BURST,
    output logic                    M_WR_ADDR_VALID,
    input  logic                    M_WR_ADDR_READY,
    // M-side W
    output logic [DATA_WIDTH-1:0]   M_WR_DATA,
    output logic [DATA_WIDTH/8-1:0] M_WR_STRB,
    output logic                    M_WR_DATA_LAST,
    output logic                    M_WR_DATA_VALID,
    input  logic                    M_WR_DATA_READY,
    // M-side B
    input  logic [ID_WIDTH-1:0]     M_WR_BACK_ID,
    input  logic [1:0]              M_WR_BACK_RESP,
    input  logic                    M_WR_BACK_VALID,
    output logic                    M_WR_BACK_READY,
    // M-side AR
    output logic [ID_WIDTH-1:0]     M_RD_ADDR_ID,
    output logic [31:0]             M_RD_ADDR,
    output logic [7:0]              M_RD_ADDR_LEN,
    output logic [1:0]              M_RD_ADDR_BURST,
    output logic                    M_RD_ADDR_VALID,
    input  logic                    M_RD_ADDR_READY,
    // M-side R
    input  logic [ID_WIDTH-1:0]     M_RD_BACK_ID,
    input  logic [DATA_WIDTH-1:0]   M_RD_DATA,
    input  logic [1:0]              M_RD_DATA_RESP,
    input  logic                    M_RD_DATA_LAST,
    input  logic                    M_RD_DATA_VALID,
    output logic                    M_RD_DATA_READY,
    // Status
    output logic [4:0]              fifo_empty_flag,
    output logic [7:0]              WR_OUTSTANDING,
    output logic [7:0]              RD_OUTSTANDING
);
    localparam int          c_strb_w = DATA_WIDTH / 8;
    localparam int          c_ax_w   = ID_WIDTH + 32 + 8 + 2;
    localparam int          c_w_w    = DATA_WIDTH + c_strb_w + 1;
    localparam int          c_b_w    = ID_WIDTH + 2;
    localparam int          c_r_w    = ID_WIDTH + DATA_WIDTH + 2 + 1;
    localparam logic [7:0]  c_max    = 8'(MAX_OUTSTANDING);

    logic [c_ax_w-1:0] w_aw_out;
    logic [c_w_w-1:0]  w_w_out;
    logic [c_b_w-1:0]  w_b_out;
    logic [c_ax_w-1:0] w_ar_out;
    logic [c_r_w-1:0]  w_r_out;
    logic              w_aw_ready;
    logic              w_ar_ready;
    logic              w_aw_empty;
    logic              w_w_empty;
    logic              w_b_empty;
    logic              w_ar_empty;
    logic              w_r_empty;
    logic              w_wr_room;
    logic              w_rd_room;
    logic              w_aw_hs;
    logic              w_b_hs;
    logic              w_ar_hs;
    logic              w_rlast_hs;
    logic [7:0]        r_wr_cnt;
    logic [7:0]        r_rd_cnt;

    assign w_wr_room       = (r_wr_cnt < c_max);
    assign w_rd_room       = (r_rd_cnt < c_max);
    assign S_WR_ADDR_READY = w_aw_ready && w_wr_room;
    assign S_RD_ADDR_READY = w_ar_ready && w_rd_room;
    assign w_aw_hs         = S_WR_ADDR_VALID && S_WR_ADDR_READY;
    assign w_b_hs          = S_WR_BACK_VALID && S_WR_BACK_READY;
    assign w_ar_hs         = S_RD_ADDR_VALID && S_RD_ADDR_READY;
    assign w_rlast_hs      = S_RD_DATA_VALID && S_RD_DATA_READY && S_RD_DATA_LAST;

    axi_outstanding_buffer_fifo #(.WIDTH(c_ax_w), .DEPTH_LOG2(DEPTH_LOG2)) u_aw_fifo (
        .clk(BUS_CLK), .rst(BUS_RST),
        .i_push_valid(S_WR_ADDR_VALID && w_wr_room), .o_push_ready(w_aw_ready),
        .i_push_data({S_WR_ADDR_ID, S_WR_ADDR, S_WR_ADDR_LEN, S_WR_ADDR_BURST}),
        .o_pop_valid(M_WR_ADDR_VALID), .i_pop_ready(M_WR_ADDR_READY),
        .o_pop_data(w_aw_out), .o_empty(w_aw_empty)
    );
    assign {M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST} = w_aw_out;

    axi_outstanding_buffer_fifo #(.WIDTH(c_w_w), .DEPTH_LOG2(DEPTH_LOG2)) u_w_fifo (
        .clk(BUS_CLK), .rst(BUS_RST),
        .i_push_valid(S_WR_DATA_VALID), .o_push_ready(S_WR_DATA_READY),
        .i_push_data({S_WR_DATA, S_WR_STRB, S_WR_DATA_LAST}),
        .o_pop_valid(M_WR_DATA_VALID), .i_pop_ready(M_WR_DATA_READY),
        .o_pop_data(w_w_out), .o_empty(w_w_empty)
    );
    assign {M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST} = w_w_out;

    axi_outstanding_buffer_fifo #(.WIDTH(c_b_w), .DEPTH_LOG2(DEPTH_LOG2)) u_b_fifo (
        .clk(BUS_CLK), .rst(BUS_RST),
        .i_push_valid(M_WR_BACK_VALID), .o_push_ready(M_WR_BACK_READY),
        .i_push_data({M_WR_BACK_ID, M_WR_BACK_RESP}),
        .o_pop_valid(S_WR_BACK_VALID), .i_pop_ready(S_WR_BACK_READY),
        .o_pop_data(w_b_out), .o_empty(w_b_empty)
    );
    assign {S_WR_BACK_ID, S_WR_BACK_RESP} = w_b_out;

    axi_outstanding_buffer_fifo #(.WIDTH(c_ax_w), .DEPTH_LOG2(DEPTH_LOG2)) u_ar_fifo (
        .clk(BUS_CLK), .rst(BUS_RST),
        .i_push_valid(S_RD_ADDR_VALID && w_rd_room), .o_push_ready(w_ar_ready),
        .i_push_data({S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST}),
        .o_pop_valid(M_RD_ADDR_VALID), .i_pop_ready(M_RD_ADDR_READY),
        .o_pop_data(w_ar_out), .o_empty(w_ar_empty)
    );
    assign {M_RD_ADDR_ID, M_RD_ADDR, M_RD_ADDR_LEN, M_RD_ADDR_BURST} = w_ar_out;

    axi_outstanding_buffer_fifo #(.WIDTH(c_r_w), .DEPTH_LOG2(DEPTH_LOG2)) u_r_fifo (
        .clk(BUS_CLK), .rst(BUS_RST),
        .i_push_valid(M_RD_DATA_VALID), .o_push_ready(M_RD_DATA_READY),
        .i_push_data({M_RD_BACK_ID, M_RD_DATA, M_RD_DATA_RESP, M_RD_DATA_LAST}),
        .o_pop_valid(S_RD_DATA_VALID), .i_pop_ready(S_RD_DATA_READY),
        .o_pop_data(w_r_out), .o_empty(w_r_empty)
    );
    assign {S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST} = w_r_out;

    assign fifo_empty_flag = {w_r_empty, w_ar_empty, w_b_empty, w_w_empty, w_aw_empty};
    assign WR_OUTSTANDING  = r_wr_cnt;
    assign RD_OUTSTANDING  = r_rd_cnt;

    // Accept and retire in one cycle cancel; a retire at zero is ignored.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_wr_cnt <= 8'd0;
            r_rd_cnt <= 8'd0;
        end else begin
            if (w_aw_hs && !w_b_hs) begin
                r_wr_cnt <= r_wr_cnt + 8'd1;
            end else if (w_b_hs && !w_aw_hs && (r_wr_cnt != 8'd0)) begin
                r_wr_cnt <= r_wr_cnt - 8'd1;
            end
            if (w_ar_hs && !w_rlast_hs) begin
                r_rd_cnt <= r_rd_cnt + 8'd1;
            end else if (w_rlast_hs && !w_ar_hs && (r_rd_cnt != 8'd0)) begin
                r_rd_cnt <= r_rd_cnt - 8'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_outstanding_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_outstanding_buffer
// Brief    : Directed self-checking bench for axi_outstanding_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_outstanding_buffer;
    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [1:0]  S_WR_ADDR_ID;    logic [31:0] S_WR_ADDR;      logic [7:0] S_WR_ADDR_LEN;
    logic [1:0]  S_WR_ADDR_BURST; logic        S_WR_ADDR_VALID; logic      S_WR_ADDR_READY;
    logic [31:0] S_WR_DATA;       logic [3:0]  S_WR_STRB;      logic       S_WR_DATA_LAST;
    logic        S_WR_DATA_VALID; logic        S_WR_DATA_READY;
    logic [1:0]  S_WR_BACK_ID;    logic [1:0]  S_WR_BACK_RESP; logic       S_WR_BACK_VALID;
    logic        S_WR_BACK_READY;
    logic [1:0]  S_RD_ADDR_ID;    logic [31:0] S_RD_ADDR;      logic [7:0] S_RD_ADDR_LEN;
    logic [1:0]  S_RD_ADDR_BURST; logic        S_RD_ADDR_VALID; logic      S_RD_ADDR_READY;
    logic [1:0]  S_RD_BACK_ID;    logic [31:0] S_RD_DATA;      logic [1:0] S_RD_DATA_RESP;
    logic        S_RD_DATA_LAST;  logic        S_RD_DATA_VALID; logic      S_RD_DATA_READY;
    logic [1:0]  M_WR_ADDR_ID;    logic [31:0] M_WR_ADDR;      logic [7:0] M_WR_ADDR_LEN;
    logic [1:0]  M_WR_ADDR_BURST; logic        M_WR_ADDR_VALID; logic      M_WR_ADDR_READY;
    logic [31:0] M_WR_DATA;       logic [3:0]  M_WR_STRB;      logic       M_WR_DATA_LAST;
    logic        M_WR_DATA_VALID; logic        M_WR_DATA_READY;
    logic [1:0]  M_WR_BACK_ID;    logic [1:0]  M_WR_BACK_RESP; logic       M_WR_BACK_VALID;
    logic        M_WR_BACK_READY;
    logic [1:0]  M_RD_ADDR_ID;    logic [31:0] M_RD_ADDR;      logic [7:0] M_RD_ADDR_LEN;
    logic [1:0]  M_RD_ADDR_BURST; logic        M_RD_ADDR_VALID; logic      M_RD_ADDR_READY;
    logic [1:0]  M_RD_BACK_ID;    logic [31:0] M_RD_DATA;      logic [1:0] M_RD_DATA_RESP;
    logic        M_RD_DATA_LAST;  logic        M_RD_DATA_VALID; logic      M_RD_DATA_READY;
    logic [4:0]  fifo_empty_flag;
    logic [7:0]  WR_OUTSTANDING;
    logic [7:0]  RD_OUTSTANDING;

    int n_checks = 0;
    int n_pass   = 0;

    axi_outstanding_buffer #(
        .ID_WIDTH(2), .DATA_WIDTH(32), .DEPTH_LOG2(2), .MAX_OUTSTANDING(4)
    ) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .S_WR_ADDR_ID(S_WR_ADDR_ID), .S_WR_ADDR(S_WR_ADDR), .S_WR_ADDR_LEN(S_WR_ADDR_LEN),
        .S_WR_ADDR_BURST(S_WR_ADDR_BURST), .S_WR_ADDR_VALID(S_WR_ADDR_VALID),
        .S_WR_ADDR_READY(S_WR_ADDR_READY),
        .S_WR_DATA(S_WR_DATA), .S_WR_STRB(S_WR_STRB), .S_WR_DATA_LAST(S_WR_DATA_LAST),
        .S_WR_DATA_VALID(S_WR_DATA_VALID), .S_WR_DATA_READY(S_WR_DATA_READY),
        .S_WR_BACK_ID(S_WR_BACK_ID), .S_WR_BACK_RESP(S_WR_BACK_RESP),
        .S_WR_BACK_VALID(S_WR_BACK_VALID), .S_WR_BACK_READY(S_WR_BACK_READY),
        .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR), .S_RD_ADDR_LEN(S_RD_ADDR_LEN),
        .S_RD_ADDR_BURST(S_RD_ADDR_BURST), .S_RD_ADDR_VALID(S_RD_ADDR_VALID),
        .S_RD_ADDR_READY(S_RD_ADDR_READY),
        .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_DATA(S_RD_DATA), .S_RD_DATA_RESP(S_RD_DATA_RESP),
        .S_RD_DATA_LAST(S_RD_DATA_LAST), .S_RD_DATA_VALID(S_RD_DATA_VALID),
        .S_RD_DATA_READY(S_RD_DATA_READY),
        .M_WR_ADDR_ID(M_WR_ADDR_ID), .M_WR_ADDR(M_WR_ADDR), .M_WR_ADDR_LEN(M_WR_ADDR_LEN),
        .M_WR_ADDR_BURST(M_WR_ADDR_BURST), .M_WR_ADDR_VALID(M_WR_ADDR_VALID),
        .M_WR_ADDR_READY(M_WR_ADDR_READY),
        .M_WR_DATA(M_WR_DATA), .M_WR_STRB(M_WR_STRB), .M_WR_DATA_LAST(M_WR_DATA_LAST),
        .M_WR_DATA_VALID(M_WR_DATA_VALID), .M_WR_DATA_READY(M_WR_DATA_READY),
        .M_WR_BACK_ID(M_WR_BACK_ID), .M_WR_BACK_RESP(M_WR_BACK_RESP),
        .M_WR_BACK_VALID(M_WR_BACK_VALID), .M_WR_BACK_READY(M_WR_BACK_READY),
        .M_RD_ADDR_ID(M_RD_ADDR_ID), .M_RD_ADDR(M_RD_ADDR), .M_RD_ADDR_LEN(M_RD_ADDR_LEN),
        .M_RD_ADDR_BURST(M_RD_ADDR_BURST), .M_RD_ADDR_VALID(M_RD_ADDR_VALID),
        .M_RD_ADDR_READY(M_RD_ADDR_READY),
        .M_RD_BACK_ID(M_RD_BACK_ID), .M_RD_DATA(M_RD_DATA), .M_RD_DATA_RESP(M_RD_DATA_RESP),
        .M_RD_DATA_LAST(M_RD_DATA_LAST), .M_RD_DATA_VALID(M_RD_DATA_VALID),
        .M_RD_DATA_READY(M_RD_DATA_READY),
        .fifo_empty_flag(fifo_empty_flag), .WR_OUTSTANDING(WR_OUTSTANDING),
        .RD_OUTSTANDING(RD_OUTSTANDING)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    initial begin
        BUS_RST = 1'b1;
        S_WR_ADDR_ID = '0; S_WR_ADDR = '0; S_WR_ADDR_LEN = '0; S_WR_ADDR_BURST = '0;
        S_WR_ADDR_VALID = 0; S_WR_DATA = '0; S_WR_STRB = '0; S_WR_DATA_LAST = 0;
        S_WR_DATA_VALID = 0; S_WR_BACK_READY = 0;
        S_RD_ADDR_ID = '0; S_RD_ADDR = '0; S_RD_ADDR_LEN = '0; S_RD_ADDR_BURST = '0;
        S_RD_ADDR_VALID = 0; S_RD_DATA_READY = 0;
        M_WR_ADDR_READY = 1; M_WR_DATA_READY = 1; M_RD_ADDR_READY = 1;
        M_WR_BACK_ID = '0; M_WR_BACK_RESP = '0; M_WR_BACK_VALID = 0;
        M_RD_BACK_ID = '0; M_RD_DATA = '0; M_RD_DATA_RESP = '0; M_RD_DATA_LAST = 0;
        M_RD_DATA_VALID = 0;

        // Reset state
        tick(); tick();
        check_eq("rst_readys", 64'({S_WR_ADDR_READY, S_WR_DATA_READY, S_RD_ADDR_READY,
                                    M_WR_BACK_READY, M_RD_DATA_READY}), 64'd0);
        check_eq("rst_valids", 64'({M_WR_ADDR_VALID, M_WR_DATA_VALID, M_RD_ADDR_VALID,
                                    S_WR_BACK_VALID, S_RD_DATA_VALID}), 64'd0);
        check_eq("rst_empty", 64'(fifo_empty_flag), 64'h1f);
        check_eq("rst_cnts", 64'({WR_OUTSTANDING, RD_OUTSTANDING}), 64'd0);
        BUS_RST = 1'b0;
        #1;
        check_eq("rel_ready_lo", 64'(S_WR_ADDR_READY), 64'd0);
        tick();
        check_eq("rel_readys", 64'({S_WR_ADDR_READY, S_WR_DATA_READY, S_RD_ADDR_READY,
                                    M_WR_BACK_READY, M_RD_DATA_READY}), 64'h1f);

        // Single write
        S_WR_ADDR_ID = 2'd1; S_WR_ADDR = 32'h100; S_WR_ADDR_LEN = 8'd0; S_WR_ADDR_BURST = 2'd1;
        S_WR_ADDR_VALID = 1; S_WR_DATA = 32'hCAFE_0001; S_WR_STRB = 4'hF; S_WR_DATA_LAST = 1;
        S_WR_DATA_VALID = 1;
        tick();
        S_WR_ADDR_VALID = 0; S_WR_DATA_VALID = 0;
        check_eq("aw_valid", 64'(M_WR_ADDR_VALID), 64'd1);
        check_eq("aw_fields", 64'({M_WR_ADDR_ID, M_WR_ADDR, M_WR_ADDR_LEN, M_WR_ADDR_BURST}),
                 64'({2'd1, 32'h100, 8'd0, 2'd1}));
        check_eq("w_fields", 64'({M_WR_DATA_VALID, M_WR_DATA, M_WR_STRB, M_WR_DATA_LAST}),
                 64'({1'b1, 32'hCAFE_0001, 4'hF, 1'b1}));
        check_eq("wr_out_1", 64'(WR_OUTSTANDING), 64'd1);
        tick();
        check_eq("aw_drained", 64'(M_WR_ADDR_VALID), 64'd0);
        check_eq("empty_all", 64'(fifo_empty_flag), 64'h1f);
        M_WR_BACK_ID = 2'd1; M_WR_BACK_RESP = 2'd0; M_WR_BACK_VALID = 1;
        tick();
        M_WR_BACK_VALID = 0;
        check_eq("b_fields", 64'({S_WR_BACK_VALID, S_WR_BACK_ID, S_WR_BACK_RESP}),
                 64'({1'b1, 2'd1, 2'd0}));
        check_eq("wr_out_hold", 64'(WR_OUTSTANDING), 64'd1);
        S_WR_BACK_READY = 1;
        tick();
        S_WR_BACK_READY = 0;
        check_eq("wr_out_0", 64'(WR_OUTSTANDING), 64'd0);
        check_eq("b_popped", 64'(S_WR_BACK_VALID), 64'd0);

        // Outstanding limit on reads
        for (int i = 0; i < 4; i++) begin
            S_RD_ADDR_ID = 2'(i); S_RD_ADDR = 32'h2000 + 32'(i * 16); S_RD_ADDR_VALID = 1;
            tick();
            check_eq("rd_out_inc", 64'(RD_OUTSTANDING), 64'(i + 1));
            if (i == 0) check_eq("ar_addr", 64'({M_RD_ADDR_VALID, M_RD_ADDR}), 64'({1'b1, 32'h2000}));
        end
        S_RD_ADDR_ID = 2'd0; S_RD_ADDR = 32'h2040;
        check_eq("ar_blocked", 64'(S_RD_ADDR_READY), 64'd0);
        tick();
        check_eq("rd_out_cap", 64'({S_RD_ADDR_READY, RD_OUTSTANDING}), 64'({1'b0, 8'd4}));
        M_RD_DATA_VALID = 1; M_RD_DATA_LAST = 1; M_RD_DATA = 32'h55;
        tick();
        M_RD_DATA_VALID = 0;
        S_RD_DATA_READY = 1;
        tick();
        check_eq("rd_out_dec", 64'({S_RD_ADDR_READY, RD_OUTSTANDING}), 64'({1'b1, 8'd3}));
        tick();
        S_RD_ADDR_VALID = 0;
        check_eq("ar5_accepted", 64'(RD_OUTSTANDING), 64'd4);
        M_RD_DATA_VALID = 1;
        repeat (4) tick();
        M_RD_DATA_VALID = 0;
        repeat (2) tick();
        check_eq("rd_out_drain", 64'(RD_OUTSTANDING), 64'd0);
        S_RD_DATA_READY = 0;

        // Full W FIFO, no push-through on a full pop
        M_WR_DATA_READY = 0; S_WR_DATA_VALID = 1; S_WR_STRB = 4'h3;
        for (int i = 0; i < 4; i++) begin
            S_WR_DATA = 32'(i);
            tick();
        end
        S_WR_DATA = 32'd4;
        check_eq("w_full_ready", 64'(S_WR_DATA_READY), 64'd0);
        tick();
        check_eq("w_full_head", 64'({S_WR_DATA_READY, M_WR_DATA}), 64'({1'b0, 32'd0}));
        M_WR_DATA_READY = 1;
        tick();
        S_WR_DATA_VALID = 0;
        for (int i = 1; i < 4; i++) begin
            check_eq("w_drain", 64'({M_WR_DATA_VALID, M_WR_DATA}), 64'({1'b1, 32'(i)}));
            tick();
        end
        check_eq("w_drained", 64'({M_WR_DATA_VALID, fifo_empty_flag[1]}), 64'b01);

        // Same-cycle accept and retire at count 2
        S_WR_ADDR_VALID = 1;
        tick(); tick();
        S_WR_ADDR_VALID = 0;
        check_eq("wr_out_2", 64'(WR_OUTSTANDING), 64'd2);
        M_WR_BACK_VALID = 1;
        tick();
        M_WR_BACK_VALID = 0;
        S_WR_ADDR_VALID = 1; S_WR_BACK_READY = 1;
        tick();
        S_WR_ADDR_VALID = 0; S_WR_BACK_READY = 0;
        check_eq("wr_out_same", 64'(WR_OUTSTANDING), 64'd2);

        // Same-cycle push/pop at occupancy 2
        M_WR_DATA_READY = 0; S_WR_DATA_VALID = 1;
        S_WR_DATA = 32'hA; tick();
        S_WR_DATA = 32'hB; tick();
        S_WR_DATA = 32'hC; M_WR_DATA_READY = 1; tick();
        S_WR_DATA_VALID = 0;
        check_eq("occ2_head_b", 64'({M_WR_DATA_VALID, M_WR_DATA}), 64'({1'b1, 32'hB}));
        tick();
        check_eq("occ2_head_c", 64'({M_WR_DATA_VALID, M_WR_DATA}), 64'({1'b1, 32'hC}));
        tick();
        check_eq("occ2_empty", 64'(M_WR_DATA_VALID), 64'd0);

        // Reset with read data buffered
        S_RD_ADDR_VALID = 1; tick(); S_RD_ADDR_VALID = 0;
        M_RD_DATA_VALID = 1;
        repeat (3) tick();
        M_RD_DATA_VALID = 0;
        check_eq("r_buffered", 64'({S_RD_DATA_VALID, fifo_empty_flag[4], RD_OUTSTANDING}),
                 64'({1'b1, 1'b0, 8'd1}));
        BUS_RST = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(S_RD_DATA_VALID), 64'd0);
        check_eq("mid_rst_empty", 64'(fifo_empty_flag), 64'h1f);
        check_eq("mid_rst_cnts", 64'({WR_OUTSTANDING, RD_OUTSTANDING}), 64'd0);
        tick(); tick();
        BUS_RST = 1'b0;
        tick();
        check_eq("post_rst_ready", 64'({S_RD_ADDR_READY, M_RD_DATA_READY}), 64'b11);

        // 20 single-beat read returns with random stalls on both sides
        fork
            begin : p_prod
                int sent; int cyc; logic hold;
                sent = 0; cyc = 0; hold = 0;
                while (sent < 20 && cyc < 400) begin
                    if (!hold) M_RD_DATA_VALID = ($urandom_range(0, 3) != 0);
                    M_RD_DATA = 32'hA000 + 32'(sent); M_RD_DATA_LAST = 1;
                    M_RD_BACK_ID = 2'(sent);
                    @(negedge BUS_CLK);
                    hold = M_RD_DATA_VALID && !M_RD_DATA_READY;
                    if (M_RD_DATA_VALID && M_RD_DATA_READY) sent++;
                    tick();
                    cyc++;
                end
                M_RD_DATA_VALID = 0;
            end
            begin : p_cons
                int rcv; int cyc;
                rcv = 0; cyc = 0;
                while (rcv < 20 && cyc < 400) begin
                    S_RD_DATA_READY = ($urandom_range(0, 2) != 0);
                    @(negedge BUS_CLK);
                    if (S_RD_DATA_VALID && S_RD_DATA_READY) begin
                        check_eq("r_order", 64'({S_RD_BACK_ID, S_RD_DATA}),
                                 64'({2'(rcv), 32'hA000 + 32'(rcv)}));
                        rcv++;
                    end
                    tick();
                    cyc++;
                end
                S_RD_DATA_READY = 0;
                check_eq("r_count", 64'(rcv), 64'd20);
            end
        join
        tick();
        check_eq("r_wrap_empty", 64'({fifo_empty_flag[4], RD_OUTSTANDING}), 64'({1'b1, 8'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
